// File: rtl/present80_pkg.sv
// present80_pkg
//  Shared definitions for the PRESENT-80 Wishbone controller: register
//  offsets inside the 64-byte window, CTRL/STATUS bit positions, the
//  sequencing FSM state type and byte-mask helpers.
package present80_pkg;

  localparam int NUM_ROUNDS_DEF = 31;

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h04;
  localparam logic [5:0] OFF_KEY0   = 6'h08;
  localparam logic [5:0] OFF_KEY1   = 6'h0C;
  localparam logic [5:0] OFF_KEY2   = 6'h10;
  localparam logic [5:0] OFF_PT0    = 6'h14;
  localparam logic [5:0] OFF_PT1    = 6'h18;
  localparam logic [5:0] OFF_CT0    = 6'h1C;
  localparam logic [5:0] OFF_CT1    = 6'h20;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_CAPT  = 3'd4
  } state_t;

  function automatic logic [31:0] sel_to_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/present80_wb_if.sv
// present80_wb_if
//  Wishbone slave front end: window decode, single-cycle ack generation,
//  write strobe with byte mask, and registered read mux.
//  Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   cyc, stb, we, sel, adr,  Wishbone request
//   dat_w
//   ack, dat_r               Wishbone response (dat_r is 0 when ack is 0)
//   wr_en, wr_off, wr_data,  write strobe towards the register file; valid
//   wr_mask                  on the edge that raises ack
//   irq_en, busy, done, key, current register contents for reads
//   pt, ct
module present80_wb_if
  import present80_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cyc,
  input  logic        stb,
  input  logic        we,
  input  logic [3:0]  sel,
  input  logic [31:0] adr,
  input  logic [31:0] dat_w,
  output logic        ack,
  output logic [31:0] dat_r,
  output logic        wr_en,
  output logic [5:0]  wr_off,
  output logic [31:0] wr_data,
  output logic [31:0] wr_mask,
  input  logic        irq_en,
  input  logic        busy,
  input  logic        done,
  input  logic [79:0] key,
  input  logic [63:0] pt,
  input  logic [63:0] ct
);

  logic        in_window;
  logic        hit;
  logic [5:0]  off;
  logic [31:0] rd_mux;

  assign in_window = (adr[31:6] == BASE_ADDR[31:6]);
  // Unaligned byte offsets fall through to the unmapped (read-0) case.
  assign off       = adr[5:0];
  // Blocking on a pending ack guarantees a dead cycle between acks.
  assign hit       = cyc & stb & in_window & ~ack;

  assign wr_en   = hit & we;
  assign wr_off  = off;
  assign wr_data = dat_w;
  assign wr_mask = sel_to_mask(sel);

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en;
      OFF_STATUS: begin
        rd_mux[STAT_BUSY] = busy;
        rd_mux[STAT_DONE] = done;
      end
      OFF_KEY0:   rd_mux = key[31:0];
      OFF_KEY1:   rd_mux = key[63:32];
      OFF_KEY2:   rd_mux = {16'h0000, key[79:64]};
      OFF_PT0:    rd_mux = pt[31:0];
      OFF_PT1:    rd_mux = pt[63:32];
      OFF_CT0:    rd_mux = ct[31:0];
      OFF_CT1:    rd_mux = ct[63:32];
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack   <= 1'b0;
      dat_r <= '0;
    end else begin
      ack   <= hit;
      dat_r <= (hit && !we) ? rd_mux : '0;
    end
  end

endmodule

// File: rtl/present80_wb_ctrl.sv
// present80_wb_ctrl
//  Wishbone-controlled sequencer for an iterative PRESENT-80 round datapath.
//  Holds KEY/PT/CT registers and runs LOAD -> NUM_ROUNDS rounds -> final
//  key whitening -> capture, then raises DONE (and irq_o if enabled).
//  Ports:
//   wb_clk_i, wb_rst_ni       clock, synchronous active-low reset
//   wbs_*                     Wishbone slave interface
//   dp_load_o                 pulse: datapath loads dp_pt_o / dp_key_o
//   dp_key_o, dp_pt_o         key / plaintext registers
//   dp_round_o, dp_rcnt_o     round enable and round counter (1..NUM_ROUNDS)
//   dp_final_o                pulse: final round-key XOR
//   dp_state_i                datapath state, ciphertext during CAPT
//   irq_o                     DONE & IRQ_EN
module present80_wb_ctrl
  import present80_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        dp_load_o,
  output logic [79:0] dp_key_o,
  output logic [63:0] dp_pt_o,
  output logic        dp_round_o,
  output logic [4:0]  dp_rcnt_o,
  output logic        dp_final_o,
  input  logic [63:0] dp_state_i,
  output logic        irq_o
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  state_t      state;
  logic [4:0]  rcnt;
  logic        done;
  logic        irq_en;
  logic [79:0] key;
  logic [63:0] pt;
  logic [63:0] ct;
  logic        busy;

  logic        wr_en;
  logic [5:0]  wr_off;
  logic [31:0] wr_data;
  logic [31:0] wr_mask;
  logic        start_req;
  logic        done_clr;

  present80_wb_if #(.BASE_ADDR(BASE_ADDR)) u_wb_if (
    .clk     (wb_clk_i),
    .rst_n   (wb_rst_ni),
    .cyc     (wbs_cyc_i),
    .stb     (wbs_stb_i),
    .we      (wbs_we_i),
    .sel     (wbs_sel_i),
    .adr     (wbs_adr_i),
    .dat_w   (wbs_dat_i),
    .ack     (wbs_ack_o),
    .dat_r   (wbs_dat_o),
    .wr_en   (wr_en),
    .wr_off  (wr_off),
    .wr_data (wr_data),
    .wr_mask (wr_mask),
    .irq_en  (irq_en),
    .busy    (busy),
    .done    (done),
    .key     (key),
    .pt      (pt),
    .ct      (ct)
  );

  assign busy      = (state != ST_IDLE);
  assign start_req = wr_en && (wr_off == OFF_CTRL) &&
                     wr_mask[CTRL_START] && wr_data[CTRL_START];
  assign done_clr  = wr_en && (wr_off == OFF_STATUS) &&
                     wr_mask[STAT_DONE] && wr_data[STAT_DONE];

  assign dp_key_o  = key;
  assign dp_pt_o   = pt;
  assign dp_rcnt_o = rcnt;
  assign irq_o     = done & irq_en;

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state      <= ST_IDLE;
      rcnt       <= '0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      key        <= '0;
      pt         <= '0;
      ct         <= '0;
      dp_load_o  <= 1'b0;
      dp_round_o <= 1'b0;
      dp_final_o <= 1'b0;
    end else begin
      dp_load_o  <= 1'b0;
      dp_final_o <= 1'b0;

      // KEY/PT are frozen while a run is in flight so the datapath sees stable inputs.
      if (wr_en && !busy) begin
        case (wr_off)
          OFF_KEY0: key[31:0]  <= merge_bytes(key[31:0], wr_data, wr_mask);
          OFF_KEY1: key[63:32] <= merge_bytes(key[63:32], wr_data, wr_mask);
          OFF_KEY2: key[79:64] <= (key[79:64] & ~wr_mask[15:0]) |
                                  (wr_data[15:0] & wr_mask[15:0]);
          OFF_PT0:  pt[31:0]   <= merge_bytes(pt[31:0], wr_data, wr_mask);
          OFF_PT1:  pt[63:32]  <= merge_bytes(pt[63:32], wr_data, wr_mask);
          default: ;
        endcase
      end

      if (wr_en && (wr_off == OFF_CTRL) && wr_mask[CTRL_IRQ_EN])
        irq_en <= wr_data[CTRL_IRQ_EN];

      // Clear first; the CAPT assignment below overrides it on a same-edge set.
      if (done_clr)
        done <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start_req) begin
            state     <= ST_LOAD;
            dp_load_o <= 1'b1;
            done      <= 1'b0;
          end
        end
        ST_LOAD: begin
          state      <= ST_ROUND;
          rcnt       <= 5'd1;
          dp_round_o <= 1'b1;
        end
        ST_ROUND: begin
          if (rcnt == LAST_ROUND) begin
            state      <= ST_FINAL;
            dp_round_o <= 1'b0;
            dp_final_o <= 1'b1;
          end else begin
            rcnt <= rcnt + 5'd1;
          end
        end
        ST_FINAL: begin
          state <= ST_CAPT;
        end
        ST_CAPT: begin
          ct    <= dp_state_i;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present80_wb_ctrl.sv
module tb_present80_wb_ctrl;
  import present80_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dp_load_o;
  logic [79:0] dp_key_o;
  logic [63:0] dp_pt_o;
  logic        dp_round_o;
  logic [4:0]  dp_rcnt_o;
  logic        dp_final_o;
  logic [63:0] dp_state_i;
  logic        irq_o;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc_cnt = 0;
  int unsigned last_acc = 0;
  int unsigned start_cyc = 0;
  int          n_load = 0;
  int          n_round = 0;
  int          n_final = 0;

  logic [63:0] dp_st = '0;
  logic [79:0] dp_k = '0;

  present80_wb_ctrl #(.BASE_ADDR(BASE), .NUM_ROUNDS(31)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .dp_load_o  (dp_load_o),
    .dp_key_o   (dp_key_o),
    .dp_pt_o    (dp_pt_o),
    .dp_round_o (dp_round_o),
    .dp_rcnt_o  (dp_rcnt_o),
    .dp_final_o (dp_final_o),
    .dp_state_i (dp_state_i),
    .irq_o      (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // ---------------- PRESENT-80 primitives ----------------
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h2174_8FE3_DA09_B65C;
    return tbl[int'(x)*4 +: 4];
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[i*4 +: 4] = sbox(s[i*4 +: 4]);
    return o;
  endfunction

  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 64; i++) o[(i == 63) ? 63 : (i * 16) % 63] = s[i];
    return o;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] n;
    n = {k[18:0], k[79:19]};
    n[79:76] = sbox(n[79:76]);
    n[19:15] = n[19:15] ^ rc;
    return n;
  endfunction

  // Whole-cipher reference: 31 rounds then final whitening.
  function automatic logic [63:0] present_ref(input logic [79:0] key, input logic [63:0] pt);
    logic [63:0] st;
    logic [79:0] k;
    st = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      st = p_layer(sbox_layer(st ^ k[79:16]));
      k = key_upd(k, 5'(r));
    end
    return st ^ k[79:16];
  endfunction

  // Iterative round datapath driven by the controller.
  always @(posedge wb_clk_i) begin
    if (dp_load_o) begin
      dp_st <= dp_pt_o;
      dp_k  <= dp_key_o;
    end else if (dp_round_o) begin
      dp_st <= p_layer(sbox_layer(dp_st ^ dp_k[79:16]));
      dp_k  <= key_upd(dp_k, dp_rcnt_o);
    end else if (dp_final_o) begin
      dp_st <= dp_st ^ dp_k[79:16];
    end
  end
  assign dp_state_i = dp_st;

  always @(posedge wb_clk_i) begin
    cyc_cnt <= cyc_cnt + 1;
    if (dp_load_o)  n_load  <= n_load + 1;
    if (dp_round_o) n_round <= n_round + 1;
    if (dp_final_o) n_final <= n_final + 1;
  end

  function automatic logic [31:0] A(input logic [5:0] off);
    return BASE + {26'b0, off};
  endfunction

  // ---------------- bus tasks ----------------
  task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rd);
    bit got;
    got = 0;
    rd = '0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = wd; wbs_sel_i = sel;
    for (int i = 0; i < 4; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got = 1; rd = wbs_dat_o; last_acc = cyc_cnt;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_ack adr=%h: got no ack, required ack", adr);
    end
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(1'b1, adr, d, 4'hF, dummy);
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    wb_access(1'b0, adr, '0, 4'h0, d);
  endtask

  task automatic load_regs(input logic [79:0] k, input logic [63:0] p);
    wb_write(A(OFF_KEY0), k[31:0]);
    wb_write(A(OFF_KEY1), k[63:32]);
    wb_write(A(OFF_KEY2), {16'hA5A5, k[79:64]});
    wb_write(A(OFF_PT0), p[31:0]);
    wb_write(A(OFF_PT1), p[63:32]);
  endtask

  task automatic start_op(input logic irq);
    wb_write(A(OFF_CTRL), {30'b0, irq, 1'b1});
    start_cyc = last_acc;
  endtask

  task automatic wait_until(input int unsigned target);
    for (int i = 0; i < 200 && cyc_cnt < target; i++) begin
      @(posedge wb_clk_i); #1;
    end
  endtask

  task automatic wait_done(output bit ok);
    logic [31:0] s;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      wb_read(A(OFF_STATUS), s);
      if (s[1]) ok = 1;
    end
  endtask

  task automatic read_ct(output logic [63:0] ct);
    logic [31:0] lo, hi;
    wb_read(A(OFF_CT0), lo);
    wb_read(A(OFF_CT1), hi);
    ct = {hi, lo};
  endtask

  function automatic logic [79:0] rand80();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    wb_rst_ni = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checks++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== '0) begin errors++;
      $display("FAIL reset_bus got ack=%b dat=%h want 0/0", wbs_ack_o, wbs_dat_o); end
    checks++; if ({dp_load_o, dp_round_o, dp_final_o} !== 3'b000) begin errors++;
      $display("FAIL reset_pulses got %b want 000", {dp_load_o, dp_round_o, dp_final_o}); end
    checks++; if (dp_rcnt_o !== 5'd0 || irq_o !== 1'b0) begin errors++;
      $display("FAIL reset_rcnt_irq got %0d/%b want 0/0", dp_rcnt_o, irq_o); end
    checks++; if (dp_key_o !== '0 || dp_pt_o !== '0) begin errors++;
      $display("FAIL reset_keypt got %h/%h want 0/0", dp_key_o, dp_pt_o); end
    wb_rst_ni = 1'b1;
    wb_read(A(OFF_STATUS), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status got %h want 0", d); end
    wb_read(A(OFF_CTRL), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
    wb_read(A(OFF_CT1), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ct1 got %h want 0", d); end
  endtask

  task automatic test_bus();
    logic [31:0] d;
    bit seen;
    repeat (2) @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = A(6'h30); wbs_sel_i = 4'h0;
    @(posedge wb_clk_i); #1;
    checks++; if (wbs_ack_o !== 1'b1 || wbs_dat_o !== 32'h0) begin errors++;
      $display("FAIL unmapped_read got ack=%b dat=%h want 1/0", wbs_ack_o, wbs_dat_o); end
    @(posedge wb_clk_i); #1;
    checks++; if (wbs_ack_o !== 1'b0 || wbs_dat_o !== 32'h0) begin errors++;
      $display("FAIL ack_gap got ack=%b dat=%h want 0/0", wbs_ack_o, wbs_dat_o); end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_adr_i = BASE + 32'h40;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) seen = 1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    checks++; if (seen) begin errors++; $display("FAIL out_of_window got ack want none"); end
    wb_write(A(OFF_PT0), 32'h1122_3344);
    wb_access(1'b1, A(OFF_PT0), 32'hAABB_CCDD, 4'b0010, d);
    wb_read(A(OFF_PT0), d);
    checks++; if (d !== 32'h1122_CC44) begin errors++;
      $display("FAIL byte_sel got %h want 1122cc44", d); end
  endtask

  task automatic test_known_vectors();
    logic [79:0] kv [3];
    logic [63:0] pv [3];
    logic [63:0] cv [3];
    logic [63:0] ct;
    logic [31:0] d;
    bit ok;
    int bl, br, bf;
    kv[0] = '0;  pv[0] = '0;  cv[0] = 64'h5579_C138_7B22_8445;
    kv[1] = '1;  pv[1] = '0;  cv[1] = 64'hE72C_46C0_F594_5049;
    kv[2] = '0;  pv[2] = '1;  cv[2] = 64'hA112_FFC7_2F68_417B;
    for (int v = 0; v < 3; v++) begin
      load_regs(kv[v], pv[v]);
      bl = n_load; br = n_round; bf = n_final;
      start_op(1'b0);
      if (v == 0) begin
        wait_until(start_cyc + 33);
        wb_read(A(OFF_STATUS), d);
        checks++; if (d !== 32'h1 || last_acc != start_cyc + 34) begin errors++;
          $display("FAIL status_before_done got %h at +%0d want 1 at +34", d, last_acc - start_cyc); end
      end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL done_timeout vec%0d got no DONE want DONE", v); end
      read_ct(ct);
      checks++; if (ct !== cv[v] || ct !== present_ref(kv[v], pv[v])) begin errors++;
        $display("FAIL known_ct vec%0d got %h want %h", v, ct, cv[v]); end
      checks++; if (n_load - bl != 1 || n_round - br != 31 || n_final - bf != 1) begin errors++;
        $display("FAIL pulse_counts got %0d/%0d/%0d want 1/31/1", n_load - bl, n_round - br, n_final - bf); end
    end
  endtask

  task automatic test_irq();
    logic [63:0] ct;
    logic [31:0] d;
    int rise;
    load_regs('1, '1);
    start_op(1'b1);
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge wb_clk_i); #1;
      if (irq_o && rise < 0) rise = int'(cyc_cnt - start_cyc);
    end
    checks++; if (rise != 34) begin errors++; $display("FAIL irq_latency got %0d want 34", rise); end
    read_ct(ct);
    checks++; if (ct !== 64'h3333_DCD3_2132_10D2) begin errors++;
      $display("FAIL irq_ct got %h want 3333dcd3213210d2", ct); end
    wb_read(A(OFF_CTRL), d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL ctrl_readback got %h want 2", d); end
    wb_write(A(OFF_STATUS), 32'h2);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_w1c got %b want 0", irq_o); end
    wb_write(A(OFF_CTRL), 32'h0);
  endtask

  task automatic test_done_race();
    logic [31:0] d;
    load_regs(rand80(), rand64());
    start_op(1'b0);
    wait_until(start_cyc + 33);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = A(OFF_STATUS); wbs_dat_i = 32'h2; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1;
    checks++; if (wbs_ack_o !== 1'b1 || cyc_cnt != start_cyc + 34) begin errors++;
      $display("FAIL race_ack got ack=%b at +%0d want 1 at +34", wbs_ack_o, cyc_cnt - start_cyc); end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wb_read(A(OFF_STATUS), d);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL race_set_wins got %h want 2", d); end
    wb_write(A(OFF_STATUS), 32'h2);
    wb_read(A(OFF_STATUS), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_clear got %h want 0", d); end
  endtask

  task automatic test_busy_writes();
    logic [79:0] k;
    logic [63:0] p, ct;
    logic [31:0] d;
    bit ok;
    int bl;
    k = rand80(); p = rand64();
    load_regs(k, p);
    bl = n_load;
    start_op(1'b0);
    wait_until(start_cyc + 10);
    wb_write(A(OFF_KEY0), 32'hDEAD_BEEF);
    wb_write(A(OFF_PT0), ~p[31:0]);
    wb_write(A(OFF_CTRL), 32'h1);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_done_timeout got no DONE want DONE"); end
    wb_read(A(OFF_KEY0), d);
    checks++; if (d !== k[31:0]) begin errors++; $display("FAIL busy_key0 got %h want %h", d, k[31:0]); end
    wb_read(A(OFF_PT0), d);
    checks++; if (d !== p[31:0]) begin errors++; $display("FAIL busy_pt0 got %h want %h", d, p[31:0]); end
    checks++; if (n_load - bl != 1) begin errors++; $display("FAIL busy_loads got %0d want 1", n_load - bl); end
    read_ct(ct);
    checks++; if (ct !== present_ref(k, p)) begin errors++;
      $display("FAIL busy_ct got %h want %h", ct, present_ref(k, p)); end
  endtask

  task automatic test_back_to_back();
    logic [79:0] k;
    logic [63:0] p, ct;
    logic [31:0] d;
    bit ok;
    k = rand80(); p = rand64();
    load_regs(k, p);
    start_op(1'b0);
    wait_done(ok);
    start_op(1'b0);
    wb_read(A(OFF_STATUS), d);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL restart_status got %h want 1", d); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got no DONE want DONE"); end
    read_ct(ct);
    checks++; if (ct !== present_ref(k, p)) begin errors++;
      $display("FAIL restart_ct got %h want %h", ct, present_ref(k, p)); end
  endtask

  task automatic test_random();
    logic [79:0] k;
    logic [63:0] p, ct;
    logic [31:0] d0, d1, d2;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      k = rand80(); p = rand64();
      load_regs(k, p);
      wb_read(A(OFF_KEY0), d0);
      wb_read(A(OFF_KEY1), d1);
      wb_read(A(OFF_KEY2), d2);
      checks++; if ({d2, d1, d0} !== {16'h0, k}) begin errors++;
        $display("FAIL rand_key_rb got %h want %h", {d2, d1, d0}, {16'h0, k}); end
      wb_read(A(OFF_PT0), d0);
      wb_read(A(OFF_PT1), d1);
      checks++; if ({d1, d0} !== p) begin errors++;
        $display("FAIL rand_pt_rb got %h want %h", {d1, d0}, p); end
      start_op(1'b0);
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rand_timeout got no DONE want DONE"); end
      read_ct(ct);
      checks++; if (ct !== present_ref(k, p)) begin errors++;
        $display("FAIL rand_ct got %h want %h", ct, present_ref(k, p)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit found;
    int bl, br, bf;
    load_regs(rand80(), rand64());
    start_op(1'b1);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge wb_clk_i); #1;
      if (dp_round_o && dp_rcnt_o == 5'd12) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rcnt12_timeout got no rcnt=12 want rcnt=12"); end
    wb_rst_ni = 1'b0;
    @(posedge wb_clk_i); #1;
    checks++; if (dp_round_o !== 1'b0 || dp_rcnt_o !== 5'd0 || irq_o !== 1'b0) begin errors++;
      $display("FAIL midreset_outs got round=%b rcnt=%0d irq=%b want 0/0/0", dp_round_o, dp_rcnt_o, irq_o); end
    bl = n_load; br = n_round; bf = n_final;
    wb_rst_ni = 1'b1;
    wb_read(A(OFF_STATUS), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_status got %h want 0", d); end
    wb_read(A(OFF_CT0), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_ct0 got %h want 0", d); end
    wb_read(A(OFF_CT1), d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL midreset_ct1 got %h want 0", d); end
    repeat (40) @(posedge wb_clk_i);
    #1;
    checks++; if (n_load != bl || n_round != br || n_final != bf) begin errors++;
      $display("FAIL midreset_pulses got %0d/%0d/%0d want 0/0/0", n_load - bl, n_round - br, n_final - bf); end
  endtask

  initial begin
    test_reset();
    test_bus();
    test_known_vectors();
    test_irq();
    test_done_race();
    test_busy_writes();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
